// File: rtl/cache_controller.sv
// Two-way set-associative, write-back, write-allocate cache controller.
// Owns a 128-set SRAM whose word holds {lru, way1, way0}; refills and writes back 128-bit lines.
module cache_controller (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  input  logic [3:0]   cpu_wstrb,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_ready,
  output logic [6:0]   sram_index,
  output logic         sram_we,
  output logic [302:0] sram_wdata,
  input  logic [302:0] sram_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ack
);

  typedef enum logic [1:0] {StIdle, StCompare, StWriteback, StAllocate} state_e;

  state_e        state_q, state_d;
  logic [31:2]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          we_q;
  logic          victim_q, victim_d;
  logic          accept;

  logic [20:0]   tag_q;
  logic [6:0]    index_q;
  logic [1:0]    word_q;
  logic [150:0]  way0, way1, hit_line, new_line, victim_line, miss_line;
  logic          hit0, hit1, hit_way, miss_victim;
  logic [3:0][31:0] hit_words, wr_words;
  logic [31:0]   mask;
  logic          unused_addr;

  assign unused_addr = ^cpu_addr[1:0];
  assign tag_q   = addr_q[31:11];
  assign index_q = addr_q[10:4];
  assign word_q  = addr_q[3:2];

  // Tag lookup, victim selection and store merge on the current SRAM read.
  always_comb begin
    way0        = sram_rdata[150:0];
    way1        = sram_rdata[301:151];
    hit0        = way0[150] && (way0[148:128] == tag_q);
    hit1        = way1[150] && (way1[148:128] == tag_q);
    hit_way     = !hit0;
    hit_line    = hit0 ? way0 : way1;
    hit_words   = hit_line[127:0];
    miss_victim = !way0[150] ? 1'b0 : (!way1[150] ? 1'b1 : sram_rdata[302]);
    miss_line   = miss_victim ? way1 : way0;
    victim_line = victim_q ? way1 : way0;
    mask        = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
    wr_words    = hit_words;
    wr_words[word_q] = (hit_words[word_q] & ~mask) | (wdata_q & mask);
    new_line    = hit_line;
    if (we_q) begin
      new_line[127:0] = wr_words;
      new_line[149]   = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    accept     = 1'b0;
    sram_index = cpu_addr[10:4];
    sram_we    = 1'b0;
    sram_wdata = sram_rdata;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          accept  = 1'b1;
          state_d = StCompare;
        end
      end
      StCompare: begin
        sram_index = index_q;
        if (hit0 || hit1) begin
          cpu_ready       = 1'b1;
          cpu_rdata       = hit_words[word_q];
          sram_we         = 1'b1;
          sram_wdata[302] = ~hit_way;
          if (hit_way) sram_wdata[301:151] = new_line;
          else         sram_wdata[150:0]   = new_line;
          state_d = StIdle;
        end else begin
          victim_d = miss_victim;
          state_d  = (miss_line[150] && miss_line[149]) ? StWriteback : StAllocate;
        end
      end
      StWriteback: begin
        sram_index = index_q;
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {victim_line[148:128], index_q, 4'b0000};
        mem_wdata  = victim_line[127:0];
        if (mem_ack) state_d = StAllocate;
      end
      StAllocate: begin
        sram_index = index_q;
        mem_req    = 1'b1;
        mem_addr   = {addr_q[31:4], 4'b0000};
        if (mem_ack) begin
          sram_we = 1'b1;
          if (victim_q) sram_wdata[301:151] = {2'b10, tag_q, mem_rdata};
          else          sram_wdata[150:0]   = {2'b10, tag_q, mem_rdata};
          state_d = StCompare;
        end
      end
      default: state_d = StIdle;
    endcase
    // Outputs are silenced combinationally so an abandoned transaction drops at once.
    if (!rst_n) begin
      sram_we   = 1'b0;
      cpu_ready = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (accept) begin
        addr_q  <= cpu_addr[31:2];
        wdata_q <= cpu_wdata;
        wstrb_q <= cpu_wstrb;
        we_q    <= cpu_we;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: behavioural SRAM and a hand-driven memory port.
module tb_cache_controller;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]   cpu_wstrb = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic [6:0]   sram_index;
  logic         sram_we;
  logic [302:0] sram_wdata, sram_rdata;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;

  int nvec = 0;
  int nerr = 0;

  localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L1W = 128'h44444444_33333333_2222BBBB_11111111;
  localparam logic [127:0] L2 = 128'h88888888_77777777_66666666_55555555;
  localparam logic [127:0] L3 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] L4 = 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C;

  cache_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wstrb  (cpu_wstrb),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .sram_index (sram_index),
    .sram_we    (sram_we),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  logic [302:0] sram [128] = '{default: '0};
  always @(posedge clk) if (sram_we) sram[sram_index] <= sram_wdata;
  assign sram_rdata = sram[sram_index];

  task automatic chk(input string tag, input logic [302:0] obs, input logic [302:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; returns in the cycle after acceptance.
  task automatic start_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] st);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = st;
    @(negedge clk);
  endtask

  task automatic finish_ready(input string tag, input logic chk_rd, input logic [31:0] erd);
    chk({tag, "_ready"}, cpu_ready, 1'b1);
    if (chk_rd) chk({tag, "_rdata"}, cpu_rdata, erd);
    chk({tag, "_no_mem_req"}, mem_req, 1'b0);
    @(negedge clk);
    cpu_req = 1'b0;
    chk({tag, "_ready_pulse"}, cpu_ready, 1'b0);
  endtask

  task automatic mem_serve(input string tag, input logic ewe, input logic [31:0] eaddr,
                           input logic [127:0] ewdata, input logic [127:0] rdata,
                           input int delay, input int exp_wait);
    int t = 0;
    while (!mem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_req"}, mem_req, 1'b1);
    chk({tag, "_req_wait"}, t, exp_wait);
    chk({tag, "_we"}, mem_we, ewe);
    chk({tag, "_addr"}, mem_addr, eaddr);
    if (ewe) chk({tag, "_wdata"}, mem_wdata, ewdata);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk({tag, "_hold_req"}, mem_req, 1'b1);
      chk({tag, "_hold_addr"}, mem_addr, eaddr);
      chk({tag, "_hold_we"}, mem_we, ewe);
      if (ewe) chk({tag, "_hold_wdata"}, mem_wdata, ewdata);
      chk({tag, "_no_ready"}, cpu_ready, 1'b0);
    end
    mem_ack = 1'b1;
    mem_rdata = rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 128'h0);
    chk("rst_sram_we", sram_we, 1'b0);
    rst_n = 1'b1;
    cpu_addr = 32'h0000_0350;
    #1 chk("idle_index", sram_index, 7'h35);
    @(negedge clk);

    // Cold load miss to 0x1000: tag 2, set 0, way0.
    start_req(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    chk("cold_cmp_ready", cpu_ready, 1'b0);
    chk("cold_cmp_sram_we", sram_we, 1'b0);
    mem_serve("cold_fill", 1'b0, 32'h0000_1000, '0, L1, 3, 1);
    finish_ready("cold", 1'b1, 32'h1111_1111);
    chk("cold_way0_meta", sram[0][150:128], {1'b1, 1'b0, 21'd2});
    chk("cold_way0_data", sram[0][127:0], L1);
    chk("cold_way1_valid", sram[0][301], 1'b0);

    start_req(1'b0, 32'h0000_1008, 32'h0, 4'h0);
    finish_ready("hit", 1'b1, 32'h3333_3333);
    chk("hit_lru", sram[0][302], 1'b1);

    start_req(1'b1, 32'h0000_1004, 32'hAAAA_BBBB, 4'b0011);
    finish_ready("store", 1'b0, 32'h0);
    start_req(1'b0, 32'h0000_1004, 32'h0, 4'h0);
    finish_ready("store_rb", 1'b1, 32'h2222_BBBB);
    chk("store_dirty", sram[0][149], 1'b1);

    // 0x1800 lands in the empty way1; way0 becomes LRU.
    start_req(1'b0, 32'h0000_1800, 32'h0, 4'h0);
    chk("fill1_cmp_ready", cpu_ready, 1'b0);
    mem_serve("fill1", 1'b0, 32'h0000_1800, '0, L2, 1, 1);
    finish_ready("fill1", 1'b1, 32'h5555_5555);
    chk("fill1_way1_meta", sram[0][301:279], {1'b1, 1'b0, 21'd3});
    chk("fill1_lru", sram[0][302], 1'b0);

    // 0x2000 evicts dirty way0 through a slow writeback, then refills.
    start_req(1'b0, 32'h0000_2000, 32'h0, 4'h0);
    chk("evict_cmp_ready", cpu_ready, 1'b0);
    mem_serve("wb", 1'b1, 32'h0000_1000, L1W, '0, 10, 1);
    mem_serve("refill", 1'b0, 32'h0000_2000, '0, L3, 2, 0);
    finish_ready("evict", 1'b1, 32'hAAAA_AAAA);
    chk("evict_way0_meta", sram[0][150:128], {1'b1, 1'b0, 21'd4});
    chk("evict_way0_data", sram[0][127:0], L3);
    chk("evict_way1_meta", sram[0][301:279], {1'b1, 1'b0, 21'd3});
    chk("evict_way1_data", sram[0][278:151], L2);
    chk("evict_lru", sram[0][302], 1'b1);

    // Reset while ALLOCATE is waiting; a coincident ack must be ignored.
    start_req(1'b0, 32'h0000_4010, 32'h0, 4'h0);
    @(negedge clk);
    chk("abort_alloc_req", mem_req, 1'b1);
    chk("abort_alloc_addr", mem_addr, 32'h0000_4010);
    rst_n = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = L4;
    #1;
    chk("abort_rst_mem_req", mem_req, 1'b0);
    chk("abort_rst_sram_we", sram_we, 1'b0);
    chk("abort_rst_ready", cpu_ready, 1'b0);
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = '0;
    cpu_req = 1'b0;
    cpu_addr = 32'h0000_0070;
    #1;
    chk("abort_idle_index", sram_index, 7'h07);
    chk("abort_mem_req", mem_req, 1'b0);
    chk("abort_sram_we", sram_we, 1'b0);
    chk("abort_ready", cpu_ready, 1'b0);
    chk("abort_set1_untouched", sram[1][150], 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_post_ready", cpu_ready, 1'b0);
    chk("abort_post_mem_req", mem_req, 1'b0);

    start_req(1'b0, 32'h0000_4014, 32'h0, 4'h0);
    chk("retry_cmp_ready", cpu_ready, 1'b0);
    mem_serve("retry_fill", 1'b0, 32'h0000_4010, '0, L4, 0, 1);
    finish_ready("retry", 1'b1, 32'h0D0D_0D0D);
    chk("retry_way0_meta", sram[1][150:128], {1'b1, 1'b0, 21'd8});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
